// File: rtl/bit_class_pkg.sv
// Shared types and bit-class helpers for the chunked 4-state bit classifier.
// Contents:
//   state_t    scan controller states
//   cls_t      2-bit class code (CLS_0, CLS_1, CLS_X, CLS_Z)
//   classify() maps a single 4-state bit to its class using case equality
package bit_class_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] cls_t;

  localparam cls_t CLS_0 = 2'd0;
  localparam cls_t CLS_1 = 2'd1;
  localparam cls_t CLS_X = 2'd2;
  localparam cls_t CLS_Z = 2'd3;

  // Anything that is not 0, 1 or z falls into the X class.
  function automatic cls_t classify(input logic b);
    if (b === 1'b0) begin
      return CLS_0;
    end
    if (b === 1'b1) begin
      return CLS_1;
    end
    if (b === 1'bz) begin
      return CLS_Z;
    end
    return CLS_X;
  endfunction

endpackage

// File: rtl/bit_class_chunk.sv
// Combinational per-chunk classifier: counts the masked-in bits of one chunk
// per class (0, 1, X, Z).
// Ports:
//   data_i   CHUNK data bits to classify
//   mask_i   CHUNK valid bits; a cleared bit is not counted in any class
//   n0_c_o   number of valid bits === 0
//   n1_c_o   number of valid bits === 1
//   nx_c_o   number of valid bits === x
//   nz_c_o   number of valid bits === z
module bit_class_chunk
  import bit_class_pkg::*;
#(
  parameter int unsigned CHUNK = 4,
  parameter int unsigned PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] data_i,
  input  logic [CHUNK-1:0] mask_i,
  output logic [PW-1:0]    n0_c_o,
  output logic [PW-1:0]    n1_c_o,
  output logic [PW-1:0]    nx_c_o,
  output logic [PW-1:0]    nz_c_o
);

  // Population count per class over the valid bits.
  always_comb begin : count_classes
    n0_c_o = '0;
    n1_c_o = '0;
    nx_c_o = '0;
    nz_c_o = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (mask_i[i]) begin
        case (classify(data_i[i]))
          CLS_0:   n0_c_o = n0_c_o + PW'(1);
          CLS_1:   n1_c_o = n1_c_o + PW'(1);
          CLS_Z:   nz_c_o = nz_c_o + PW'(1);
          default: nx_c_o = nx_c_o + PW'(1);
        endcase
      end
    end
  end

endmodule

// File: rtl/bit_class_scan_ctrl.sv
// Sequential scan controller: walks an N-bit word CHUNK bits per cycle through
// one shared bit_class_chunk and accumulates per-class counts.
// Build option: define XZ_COUNT_EN to keep separate X and Z accumulators;
// without it xs/zs are tied to 0 and non-0/1 bits are not counted.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  scan request, accepted in IDLE or DONE
//   abort  cancel an in-progress scan (wins over start)
//   ip     word to classify, captured on the accepted-start edge
//   busy   high while scanning
//   done   one-cycle pulse when counts become valid
//   zeros/ones/xs/zs  per-class counts, held until the next accepted start
module bit_class_scan_ctrl
  import bit_class_pkg::*;
#(
  parameter int unsigned N     = 20,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  ip,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] zeros,
  output logic [CW-1:0] ones,
  output logic [CW-1:0] xs,
  output logic [CW-1:0] zs
);

  localparam int unsigned NCH   = (N + CHUNK - 1) / CHUNK;
  localparam int unsigned PADW  = NCH * CHUNK;
  localparam int unsigned IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW    = $clog2(CHUNK + 1);
  localparam int unsigned LASTW = N - (NCH - 1) * CHUNK;
  // Valid bits of the final chunk; padding above N is excluded.
  localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LASTW);

  state_t           state_q, state_d;
  logic             busy_q, done_q;
  logic [PADW-1:0]  shadow_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    zeros_q, ones_q;

  logic             accept_c, scan_c, abort_c, last_c;
  logic [PADW-1:0]  ip_pad_c;
  logic [CHUNK-1:0] chunk_mask_c;
  logic [PW-1:0]    n0_c, n1_c, nx_c, nz_c;

  assign last_c       = (idx_q == IW'(NCH - 1));
  assign chunk_mask_c = last_c ? LAST_MASK : {CHUNK{1'b1}};

  // Zero-extend the captured word to a whole number of chunks.
  always_comb begin : pad_ip
    ip_pad_c        = '0;
    ip_pad_c[N-1:0] = ip;
  end

  // The shadow shifts down one chunk per scan cycle, so the current chunk is
  // always in the low CHUNK bits.
  bit_class_chunk #(
    .CHUNK (CHUNK),
    .PW    (PW)
  ) u_chunk (
    .data_i (shadow_q[CHUNK-1:0]),
    .mask_i (chunk_mask_c),
    .n0_c_o (n0_c),
    .n1_c_o (n1_c),
    .nx_c_o (nx_c),
    .nz_c_o (nz_c)
  );

  // Next-state and control decode.
  always_comb begin : fsm_next
    state_d  = state_q;
    accept_c = 1'b0;
    scan_c   = 1'b0;
    abort_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          accept_c = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else begin
          scan_c = 1'b1;
          if (last_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d  = SCAN;
          accept_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flags, shadow, index and 0/1 accumulators.
  always_ff @(posedge clk or posedge rst) begin : seq_main
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      idx_q    <= '0;
      zeros_q  <= '0;
      ones_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SCAN);
      done_q  <= (state_d == DONE);
      if (accept_c) begin
        shadow_q <= ip_pad_c;
        idx_q    <= '0;
        zeros_q  <= '0;
        ones_q   <= '0;
      end else if (abort_c) begin
        idx_q   <= '0;
        zeros_q <= '0;
        ones_q  <= '0;
      end else if (scan_c) begin
        shadow_q <= shadow_q >> CHUNK;
        idx_q    <= last_c ? '0 : idx_q + IW'(1);
        zeros_q  <= zeros_q + CW'(n0_c);
        ones_q   <= ones_q + CW'(n1_c);
      end
    end
  end

`ifdef XZ_COUNT_EN
  logic [CW-1:0] xs_q, zs_q;

  // X/Z accumulators follow the same clear/add timing as zeros/ones.
  always_ff @(posedge clk or posedge rst) begin : seq_xz
    if (rst) begin
      xs_q <= '0;
      zs_q <= '0;
    end else if (accept_c || abort_c) begin
      xs_q <= '0;
      zs_q <= '0;
    end else if (scan_c) begin
      xs_q <= xs_q + CW'(nx_c);
      zs_q <= zs_q + CW'(nz_c);
    end
  end

  assign xs = xs_q;
  assign zs = zs_q;
`else
  logic unused_xz;
  assign unused_xz = ^{nx_c, nz_c};
  assign xs        = '0;
  assign zs        = '0;
`endif

  assign busy  = busy_q;
  assign done  = done_q;
  assign zeros = zeros_q;
  assign ones  = ones_q;

endmodule

// File: tb/tb_bit_class_scan_ctrl.sv
// Directed self-checking bench for bit_class_scan_ctrl (N=20/CHUNK=4 and a
// second N=22 instance for the partial last chunk).
module tb_bit_class_scan_ctrl;

  localparam int unsigned N     = 20;
  localparam int unsigned N2    = 22;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [N-1:0]  ip;
  logic          busy, done;
  logic [CW-1:0] zeros, ones, xs, zs;

  logic          start2, abort2;
  logic [N2-1:0] ip2;
  logic          busy2, done2;
  logic [CW-1:0] zeros2, ones2, xs2, zs2;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bit_class_scan_ctrl #(.N(N), .CHUNK(CHUNK), .CW(CW)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .ip    (ip),
    .busy  (busy),
    .done  (done),
    .zeros (zeros),
    .ones  (ones),
    .xs    (xs),
    .zs    (zs)
  );

  bit_class_scan_ctrl #(.N(N2), .CHUNK(CHUNK), .CW(CW)) u_dut22 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .abort (abort2),
    .ip    (ip2),
    .busy  (busy2),
    .done  (done2),
    .zeros (zeros2),
    .ones  (ones2),
    .xs    (xs2),
    .zs    (zs2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge; returns one cycle after that edge.
  task automatic accept(input logic [N-1:0] v);
    ip    = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycle numbering: cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(input int c0, output int dc, output int bc);
    dc = 0;
    bc = 0;
    for (int c = c0; c < c0 + 24; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      if (busy) bc++;
      tick();
    end
  endtask

  logic [N-1:0] v;
  logic         probe;
  int           dc, bc, cnt;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    ip     = '0;
    start2 = 1'b0;
    abort2 = 1'b0;
    ip2    = '0;
    #12;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_zeros", 32'(zeros), 32'd0);
    chk("rst_ones",  32'(ones),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: basic pattern and latency
    accept(20'h0F0F0);
    wait_done(1, dc, bc);
    chk("t1_done_cycle", 32'(dc), 32'd6);
    chk("t1_busy_cycles", 32'(bc), 32'd5);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    chk("t1_zeros", 32'(zeros), 32'd12);
    chk("t1_ones", 32'(ones), 32'd8);
    chk("t1_xs", 32'(xs), 32'd0);
    chk("t1_zs", 32'(zs), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold_ones", 32'(ones), 32'd8);
    tick();

    // 2: X/Z classes (only observable in a 4-state simulator)
    probe = 1'bx;
    if ($isunknown(probe)) begin
      v      = '0;
      v[3:0] = 4'bxxzz;
      accept(v);
      wait_done(1, dc, bc);
      chk("t2_zeros", 32'(zeros), 32'd16);
      chk("t2_ones", 32'(ones), 32'd0);
`ifdef XZ_COUNT_EN
      chk("t2_xs", 32'(xs), 32'd2);
      chk("t2_zs", 32'(zs), 32'd2);
      chk("t2_sum", 32'(zeros) + 32'(ones) + 32'(xs) + 32'(zs), 32'd20);
`else
      chk("t2_xs", 32'(xs), 32'd0);
      chk("t2_zs", 32'(zs), 32'd0);
`endif
    end else begin
      accept(20'h0000C);
      wait_done(1, dc, bc);
      chk("t2_zeros", 32'(zeros), 32'd18);
      chk("t2_ones", 32'(ones), 32'd2);
    end
    tick();
    tick();

    // 3: N=22, partial last chunk
    ip2    = '1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    dc     = 0;
    for (int c = 1; c < 25; c++) begin
      if (done2) begin
        dc = c;
        break;
      end
      tick();
    end
    chk("t3_done_cycle", 32'(dc), 32'd7);
    chk("t3_ones", 32'(ones2), 32'd22);
    chk("t3_zeros", 32'(zeros2), 32'd0);
    tick();
    tick();

    // 4: start held during SCAN while ip changes
    ip    = 20'h00003;
    start = 1'b1;
    tick();
    ip = 20'hFFFFF;
    tick();
    tick();
    start = 1'b0;
    wait_done(3, dc, bc);
    chk("t4_done_cycle", 32'(dc), 32'd6);
    chk("t4_ones", 32'(ones), 32'd2);
    chk("t4_zeros", 32'(zeros), 32'd18);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) cnt++;
    end
    chk("t4_extra_done", 32'(cnt), 32'd0);

    // 5: abort with start in the 3rd SCAN cycle
    accept(20'hFFFFF);
    tick();
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_ones", 32'(ones), 32'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("t5_stays_idle", 32'(cnt), 32'd0);
    accept(20'hFFFFF);
    wait_done(1, dc, bc);
    chk("t5_done_cycle", 32'(dc), 32'd6);
    chk("t5_ones", 32'(ones), 32'd20);
    chk("t5_zeros", 32'(zeros), 32'd0);
    tick();

    // 6: async reset mid-scan, then full scan and back-to-back start
    accept(20'hFFFFF);
    tick();
    chk("t6_mid_ones", 32'(ones), 32'd4);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ones", 32'(ones), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    accept(20'hA5A5A);
    wait_done(1, dc, bc);
    chk("t6_done_cycle", 32'(dc), 32'd6);
    chk("t6_ones", 32'(ones), 32'd10);
    chk("t6_zeros", 32'(zeros), 32'd10);
    accept(20'h00001);
    wait_done(1, dc, bc);
    chk("t6_b2b_done_cycle", 32'(dc), 32'd6);
    chk("t6_b2b_ones", 32'(ones), 32'd1);
    chk("t6_b2b_zeros", 32'(zeros), 32'd19);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
